// File: rtl/switch_egress_queue_if.sv
// switch_egress_queue_if: input capture and ready/valid drain signals of one egress queue.
// slave  = the queue itself; master = the switch/consumer side driving it.
interface switch_egress_queue_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  in_vld;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  out_vld;
  logic                  out_rdy;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [DATA_WIDTH-1:0] out_data;

  modport slave (
    input  in_vld, addr_in, data_in, out_rdy,
    output out_vld, out_addr, out_data
  );

  modport master (
    output in_vld, addr_in, data_in, out_rdy,
    input  out_vld, out_addr, out_data
  );
endinterface

// File: rtl/switch_egress_queue.sv
// switch_egress_queue: per-port first-word-fall-through FIFO behind the address switch.
// The switch cannot stall, so an entry arriving at a full queue (with no pop) is
// discarded and reported with a one-cycle drop pulse.
// Build macro SWITCH_EGRESS_STATS_EN adds drop_cnt (saturating) and hwm outputs.
module switch_egress_queue #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
`ifdef SWITCH_EGRESS_STATS_EN
  parameter int CNT_WIDTH  = 8,
`endif
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  switch_egress_queue_if.slave   bus,
  output logic                   full,
  output logic                   empty,
  output logic [CW-1:0]          count,
  output logic                   drop
`ifdef SWITCH_EGRESS_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]   drop_cnt,
  output logic [CW-1:0]          hwm
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic [CW-1:0] count_next;
  logic          full_reg;
  logic          empty_reg;
  logic          drop_reg;
  logic          push;
  logic          pop;
  logic          overflow;
  logic [EW-1:0] head;

  // Handshake qualification and next occupancy; a pop at full makes room for the push.
  always_comb begin
    pop        = !empty_reg && bus.out_rdy;
    push       = bus.in_vld && (!full_reg || pop);
    overflow   = bus.in_vld && full_reg && !pop;
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CW'(1);
    end
  end

  // Pointers, occupancy and status flags; flags are derived from the next count so they stay in step.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      drop_reg   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg <= count_next;
      full_reg  <= (count_next == CW'(DEPTH));
      empty_reg <= (count_next == '0);
      drop_reg  <= overflow;
    end
  end

  // Entry storage; stale contents after reset are hidden because the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {bus.addr_in, bus.data_in};
    end
  end

  assign head = mem[rd_ptr_reg];

  // Fall-through head presentation, zeroed while empty.
  always_comb begin
    bus.out_vld  = !empty_reg;
    bus.out_addr = '0;
    bus.out_data = '0;
    if (!empty_reg) begin
      {bus.out_addr, bus.out_data} = head;
    end
  end

  assign full  = full_reg;
  assign empty = empty_reg;
  assign count = count_reg;
  assign drop  = drop_reg;

`ifdef SWITCH_EGRESS_STATS_EN
  logic [CNT_WIDTH-1:0] drop_cnt_reg;
  logic [CW-1:0]        hwm_reg;

  // Saturating drop counter and high-water mark of the occupancy.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      drop_cnt_reg <= '0;
      hwm_reg      <= '0;
    end else begin
      if (overflow && (drop_cnt_reg != '1)) begin
        drop_cnt_reg <= drop_cnt_reg + CNT_WIDTH'(1);
      end
      if (count_next > hwm_reg) begin
        hwm_reg <= count_next;
      end
    end
  end

  assign drop_cnt = drop_cnt_reg;
  assign hwm      = hwm_reg;
`else
  // Statistics disabled: no counters exist in this build.
`endif

endmodule

// File: tb/tb_switch_egress_queue.sv
// tb_switch_egress_queue: directed stimulus with a queue-level reference model
// compared against the DUT every cycle, plus literal expectations per scenario.
module tb_switch_egress_queue;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk;
  logic rstn;
  logic full;
  logic empty;
  logic [CW-1:0] count;
  logic drop;
`ifdef SWITCH_EGRESS_STATS_EN
  logic [7:0]    drop_cnt;
  logic [CW-1:0] hwm;
`endif

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;
  bit saw_full = 1'b0;

  switch_egress_queue_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

  switch_egress_queue #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(16),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus),
    .full(full),
    .empty(empty),
    .count(count),
    .drop(drop)
`ifdef SWITCH_EGRESS_STATS_EN
    ,
    .drop_cnt(drop_cnt),
    .hwm(hwm)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of {addr,data} advanced once per cycle.
  logic [23:0] m_q[$];
  logic [23:0] m_head;
  bit          m_drop = 1'b0;
  int          m_dcnt = 0;
  int          m_hwm  = 0;
  int          m_sz;
  bit          m_pop;
  bit          m_push;

  always @(negedge clk) begin
    m_sz   = m_q.size();
    m_head = (m_sz > 0) ? m_q[0] : 24'h0;
    if (check_en) begin
      chk("out_vld",  32'(bus.out_vld),  32'(m_sz > 0));
      chk("out_addr", 32'(bus.out_addr), 32'(m_head[23:16]));
      chk("out_data", 32'(bus.out_data), 32'(m_head[15:0]));
      chk("count",    32'(count),        32'(m_sz));
      chk("full",     32'(full),         32'(m_sz == DEPTH));
      chk("empty",    32'(empty),        32'(m_sz == 0));
      chk("drop",     32'(drop),         32'(m_drop));
`ifdef SWITCH_EGRESS_STATS_EN
      chk("drop_cnt", 32'(drop_cnt),     32'(m_dcnt));
      chk("hwm",      32'(hwm),          32'(m_hwm));
`endif
    end
    if (!rstn) begin
      m_q.delete();
      m_drop = 1'b0;
      m_dcnt = 0;
      m_hwm  = 0;
    end else begin
      m_pop  = (m_sz > 0) && bus.out_rdy;
      m_push = bus.in_vld && ((m_sz < DEPTH) || m_pop);
      m_drop = bus.in_vld && !m_push;
      if (check_en && m_pop) begin
        $display("pop  addr=%02h data=%04h", m_head[23:16], m_head[15:0]);
      end
      if (m_pop) void'(m_q.pop_front());
      if (m_push) m_q.push_back({bus.addr_in, bus.data_in});
      if (m_drop && m_dcnt < 255) m_dcnt++;
      if (m_q.size() > m_hwm) m_hwm = m_q.size();
    end
  end

  // Advance to just after the next active edge; inputs change only here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn        = 1'b0;
    bus.in_vld  = 1'b0;
    bus.addr_in = '0;
    bus.data_in = '0;
    bus.out_rdy = 1'b0;
    repeat (2) step();
    rstn     = 1'b1;
    check_en = 1'b1;

    // Reset state
    chk("rst_empty",   32'(empty),       32'd1);
    chk("rst_full",    32'(full),        32'd0);
    chk("rst_count",   32'(count),       32'd0);
    chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
    chk("rst_drop",    32'(drop),        32'd0);

    // 1: single push, visible the following cycle
    bus.in_vld = 1'b1; bus.addr_in = 8'h10; bus.data_in = 16'hBEEF;
    step();
    bus.in_vld = 1'b0;
    chk("t1_out_vld",  32'(bus.out_vld),  32'd1);
    chk("t1_out_addr", 32'(bus.out_addr), 32'h10);
    chk("t1_out_data", 32'(bus.out_data), 32'hBEEF);
    chk("t1_count",    32'(count),        32'd1);
    bus.out_rdy = 1'b1;
    step();
    bus.out_rdy = 1'b0;
    chk("t1_drained", 32'(empty), 32'd1);

    // 2: fill to full, then three back-to-back drops
    for (int i = 0; i < 8; i++) begin
      bus.in_vld = 1'b1; bus.addr_in = 8'(i); bus.data_in = 16'h0100 + 16'(i);
      step();
    end
    chk("t2_full",  32'(full),  32'd1);
    chk("t2_count", 32'(count), 32'd8);
    for (int j = 0; j < 3; j++) begin
      bus.addr_in = 8'hF0 + 8'(j); bus.data_in = 16'hDEAD;
      step();
      chk("t2_drop", 32'(drop), 32'd1);
    end
    bus.in_vld = 1'b0;
    chk("t2_count_held", 32'(count), 32'd8);
    step();
    chk("t2_drop_end", 32'(drop),         32'd0);
    chk("t2_head",     32'(bus.out_addr), 32'h00);

    // 3: push and pop together at full
    bus.in_vld = 1'b1; bus.addr_in = 8'hAA; bus.data_in = 16'hCAFE; bus.out_rdy = 1'b1;
    step();
    bus.in_vld = 1'b0;
    chk("t3_no_drop", 32'(drop),         32'd0);
    chk("t3_count",   32'(count),        32'd8);
    chk("t3_head",    32'(bus.out_addr), 32'h01);
    repeat (7) step();
    chk("t3_last_addr", 32'(bus.out_addr), 32'hAA);
    chk("t3_last_data", 32'(bus.out_data), 32'hCAFE);
    chk("t3_last_cnt",  32'(count),        32'd1);
    step();
    bus.out_rdy = 1'b0;
    chk("t3_empty", 32'(empty), 32'd1);
`ifdef SWITCH_EGRESS_STATS_EN
    chk("t6_drop_cnt", 32'(drop_cnt), 32'd3);
    chk("t6_hwm",      32'(hwm),      32'd8);
`endif

    // 4: continuous streaming through the pointer wrap, first entry is all-zero
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_vld  = 1'b1;
      bus.addr_in = 8'(i);
      bus.data_in = (i == 0) ? 16'h0000 : 16'hA000 + 16'(i);
      step();
      if (full) saw_full = 1'b1;
      if (i == 0) begin
        chk("t4_zero_vld",  32'(bus.out_vld),  32'd1);
        chk("t4_zero_addr", 32'(bus.out_addr), 32'h0);
        chk("t4_zero_data", 32'(bus.out_data), 32'h0);
      end
    end
    bus.in_vld = 1'b0;
    step();
    bus.out_rdy = 1'b0;
    chk("t4_never_full", 32'(saw_full), 32'd0);
    chk("t4_empty",      32'(empty),    32'd1);

    // 5: reset mid-operation discards contents
    for (int i = 0; i < 5; i++) begin
      bus.in_vld = 1'b1; bus.addr_in = 8'h50 + 8'(i); bus.data_in = 16'h5000 + 16'(i);
      step();
    end
    bus.in_vld = 1'b0;
    chk("t5_count_pre", 32'(count), 32'd5);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("t5_empty",    32'(empty),        32'd1);
    chk("t5_count",    32'(count),        32'd0);
    chk("t5_out_vld",  32'(bus.out_vld),  32'd0);
    chk("t5_out_addr", 32'(bus.out_addr), 32'h0);
    chk("t5_out_data", 32'(bus.out_data), 32'h0);
`ifdef SWITCH_EGRESS_STATS_EN
    chk("t5_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("t5_hwm",      32'(hwm),      32'd0);
`endif
    bus.out_rdy = 1'b1;
    repeat (3) step();
    bus.out_rdy = 1'b0;
    chk("t5_no_drain", 32'(bus.out_vld), 32'd0);

    // 6: fill and overflow 257 times to saturate the drop counter
    for (int i = 0; i < 8 + 257; i++) begin
      bus.in_vld = 1'b1; bus.addr_in = 8'(i); bus.data_in = 16'h6000 + 16'(i);
      step();
    end
    bus.in_vld = 1'b0;
    chk("t6_drop_hi", 32'(drop),  32'd1);
    chk("t6_count",   32'(count), 32'd8);
`ifdef SWITCH_EGRESS_STATS_EN
    chk("t6_sat",     32'(drop_cnt), 32'hFF);
    chk("t6_hwm_sat", 32'(hwm),      32'd8);
`endif
    bus.out_rdy = 1'b1;
    repeat (9) step();
    bus.out_rdy = 1'b0;
    chk("t6_drained", 32'(empty), 32'd1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
